mcu_spi_target: RTL and testbench
=================================

// Module: mcu_spi_target
// PURPOSE
//  - SPI target front-end between the board MCU and the FPGA control blocks (sysctrl, hid, sdc).
//  - Deserialises MCU SPI frames into byte strobes with a start-of-command flag.
//  - Returns each target's reply byte on MISO with one byte of delay.
//  - First byte of a frame selects the target; second byte is the command; the rest are payload.
// PARAMETERS
//  SYNC_STAGES     2          flip-flop stages on spi_cs_n/spi_sck/spi_mosi (>=2)
//  NUM_TARGETS     4          number of one-hot target selects
//  TIMEOUT_CYCLES  1_000_000  stall limit with CS low (used only with MCU_SPI_TIMEOUT_EN)
// PORTS
//  clk              in   1            system clock; must be >= 8x SCK frequency
//  reset_n          in   1            synchronous, active-low reset
//  spi_cs_n         in   1            MCU chip select, async, active-low
//  spi_sck          in   1            MCU SPI clock, async, mode 0 (CPOL=0, CPHA=0)
//  spi_mosi         in   1            MCU -> FPGA data, MSB first
//  spi_miso         out  1            FPGA -> MCU data, MSB first
//  target_sel       out  NUM_TARGETS  one-hot target of the current frame; 0 when idle
//  data_out_strobe  out  1            1-cycle pulse: byte valid on data_out
//  data_out_start   out  1            qualifies strobe: byte is the command (first after target)
//  data_out         out  8            received byte
//  data_in          in   8            reply byte from selected target (externally muxed)
//  frame_error      out  1            1-cycle pulse on aborted frame
// BEHAVIOUR
//  - Reset: spi_miso=0, target_sel=0, data_out_strobe=0, data_out_start=0, data_out=0, frame_error=0.
//    FSM enters WAIT_HIGH; shift registers, bit counter and timeout counter are cleared.
//  - Synchronisation: CS, SCK and MOSI pass through SYNC_STAGES. SCK rise/fall edges are detected
//    in the clk domain. MOSI is sampled on the synchronised rising edge.
//  - FSM states:
//    - WAIT_HIGH: wait for spi_cs_n high, then go to IDLE. Also used after reset and after an abort.
//    - IDLE: on synchronised CS falling edge, go to TARGET with bit counter = 0.
//    - TARGET: on the 8th rise, latch the byte as target id, go to CMD.
//      - id < NUM_TARGETS: target_sel = 1<<id from the next cycle.
//      - id >= NUM_TARGETS: target_sel stays 0; rest of the frame is received but produces no strobes.
//      - No strobe is issued for the target byte.
//    - CMD: on the 8th rise, data_out=byte, strobe=1 and start=1 in the next cycle; go to DATA.
//    - DATA: each further byte gives strobe=1, start=0 in the cycle after the 8th rise. Stays in DATA.
//  - Any state, CS rising edge:
//    - return to IDLE and clear target_sel in the same cycle;
//    - discard a partial byte with no strobe and no error;
//    - spi_miso=0.
//  - MISO timing:
//    - tx shift register loads data_in exactly 2 clk after each data_out_strobe (consumer has 1 cycle to update).
//    - spi_miso = tx[7]; tx shifts left on each synchronised SCK falling edge.
//    - Reply to byte k appears during byte k+1; target byte and command byte shift out 0x00.
//    - Unselected target: MISO held 0.
//  - Bit counter is 3-bit and wraps 7->0 at a byte boundary; bytes per frame are unlimited.
//  - Simultaneous SCK rise and CS rise: the CS rise wins; the byte is not completed.
//  - Reset asserted mid-frame: frame dropped. If CS is still low at reset release, stay in WAIT_HIGH until CS goes high.
// CONFIGURATION
//  MCU_SPI_TIMEOUT_EN defined:
//    - 32-bit stall counter runs while CS is low and not in WAIT_HIGH; it clears on every SCK edge.
//    - On reaching TIMEOUT_CYCLES: frame_error pulses, target_sel=0, no strobe, FSM -> WAIT_HIGH.
//  MCU_SPI_TIMEOUT_EN undefined:
//    - No counter; frame_error is tied 0; a stalled frame waits indefinitely.
// STRUCTURE
//  - mcu_spi_pkg: FSM state enum (WAIT_HIGH, IDLE, TARGET, CMD, DATA) and target id constants
//    (TGT_SYS=0, TGT_HID=1, TGT_SDC=2, TGT_PORT=3).
//  - One sub-module, spi_sync_edge: N-stage synchroniser plus rise/fall pulse outputs.
//    Three instances: CS, SCK, MOSI (MOSI uses level only).
// TESTING
//  1. Frame 00,00,AA,BB with data_in=5C after the first strobe and 42 after the second:
//     - target_sel=0001;
//     - strobes deliver 00 (start=1), then AA and BB (start=0);
//     - MISO shifts out 00,00,5C,42.
//  2. Frame 02,05,01: target_sel=0100 during the frame and 0000 one cycle after the CS rise; 2 strobes; first has start=1.
//  3. Target id 07: no strobe for the whole frame, MISO constant 0, target_sel=0000.
//  4. CS rises after 5 bits of the command byte: no strobe, FSM IDLE. Next frame 01,03 works normally: one strobe, data_out=03, start=1.
//  5. reset_n pulsed low mid-frame with CS held low: outputs return to reset values; a new frame is accepted only after CS goes high then low.
//  6. MCU_SPI_TIMEOUT_EN, TIMEOUT_CYCLES=100, SCK stalled after 3 bits:
//     - frame_error pulses at cycle 100;
//     - later SCK edges are ignored until CS goes high.

Source files
------------

// File: rtl/mcu_spi_pkg.sv
// Shared types for the MCU SPI target front-end: FSM states and target ids.
package mcu_spi_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_HIGH,
        ST_IDLE,
        ST_TARGET,
        ST_CMD,
        ST_DATA
    } spi_state_e;

    localparam logic [7:0] TGT_SYS  = 8'd0;
    localparam logic [7:0] TGT_HID  = 8'd1;
    localparam logic [7:0] TGT_SDC  = 8'd2;
    localparam logic [7:0] TGT_PORT = 8'd3;

endpackage

// File: rtl/spi_sync_edge.sv
// N-stage synchroniser for an asynchronous input, with single-cycle rise/fall pulses.
module spi_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // Reset to 0 so a CS that is really low after reset is never mistaken for idle-high.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level_o = sync_q[STAGES-1];
    assign rise_o  = sync_q[STAGES-1] & ~prev_q;
    assign fall_o  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/mcu_spi_target.sv
// SPI (mode 0) target: frames are target byte, command byte, payload; replies lag one byte.
// Optional stall timeout with frame_error is enabled by defining MCU_SPI_TIMEOUT_EN.
module mcu_spi_target
    import mcu_spi_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int NUM_TARGETS    = 4,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   spi_cs_n,
    input  logic                   spi_sck,
    input  logic                   spi_mosi,
    output logic                   spi_miso,
    output logic [NUM_TARGETS-1:0] target_sel,
    output logic                   data_out_strobe,
    output logic                   data_out_start,
    output logic [7:0]             data_out,
    input  logic [7:0]             data_in,
    output logic                   frame_error
);

    logic cs_lvl, cs_rise, cs_fall;
    logic sck_lvl_unused, sck_rise, sck_fall;
    logic mosi_lvl, mosi_rise_unused, mosi_fall_unused;

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_cs_sync (
        .clk(clk), .reset_n(reset_n), .async_i(spi_cs_n),
        .level_o(cs_lvl), .rise_o(cs_rise), .fall_o(cs_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sck_sync (
        .clk(clk), .reset_n(reset_n), .async_i(spi_sck),
        .level_o(sck_lvl_unused), .rise_o(sck_rise), .fall_o(sck_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_mosi_sync (
        .clk(clk), .reset_n(reset_n), .async_i(spi_mosi),
        .level_o(mosi_lvl), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused)
    );

    spi_state_e             state_q, state_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             rx_q, rx_d;
    logic [7:0]             tx_q, tx_d;
    logic [NUM_TARGETS-1:0] sel_q, sel_d;
    logic                   strobe_q, strobe_d;
    logic                   start_q, start_d;
    logic [7:0]             dout_q, dout_d;
    logic                   load_q, load_d;
    logic [7:0]             rx_byte;

`ifdef MCU_SPI_TIMEOUT_EN
    logic [31:0] timeout_q, timeout_d;
    logic        ferr_q, ferr_d;
`else
    logic [31:0] timeout_unused;
    assign timeout_unused = 32'(TIMEOUT_CYCLES);
`endif

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        sel_d     = sel_q;
        strobe_d  = 1'b0;
        start_d   = 1'b0;
        dout_d    = dout_q;
        load_d    = strobe_q;
        rx_byte   = {rx_q[6:0], mosi_lvl};
`ifdef MCU_SPI_TIMEOUT_EN
        ferr_d    = 1'b0;
        timeout_d = '0;
`endif
        // The fall closing a byte does not shift: the reply reload supplies the next MSB.
        if (sck_fall && bit_cnt_q != 3'd0) begin
            tx_d = {tx_q[6:0], 1'b0};
        end
        if (load_q && state_q == ST_DATA) begin
            tx_d = data_in;
        end

        case (state_q)
            ST_WAIT_HIGH: begin
                if (cs_lvl) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d   = ST_TARGET;
                    bit_cnt_d = '0;
                    rx_d      = '0;
                    tx_d      = '0;
                end
            end
            default: begin
                if (sck_rise) begin
                    rx_d      = rx_byte;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        if (state_q == ST_TARGET) begin
                            state_d = ST_CMD;
                            for (int i = 0; i < NUM_TARGETS; i++) begin
                                sel_d[i] = (rx_byte == 8'(i));
                            end
                        end else begin
                            state_d = ST_DATA;
                            if (|sel_q) begin
                                strobe_d = 1'b1;
                                start_d  = (state_q == ST_CMD);
                                dout_d   = rx_byte;
                            end
                        end
                    end
                end
            end
        endcase

`ifdef MCU_SPI_TIMEOUT_EN
        if (!cs_lvl && state_q != ST_WAIT_HIGH && !sck_rise && !sck_fall) begin
            if (timeout_q == 32'(TIMEOUT_CYCLES - 1)) begin
                ferr_d   = 1'b1;
                state_d  = ST_WAIT_HIGH;
                sel_d    = '0;
                strobe_d = 1'b0;
                start_d  = 1'b0;
                tx_d     = '0;
            end else begin
                timeout_d = timeout_q + 32'd1;
            end
        end
`endif

        // A CS rise beats a coincident SCK rise and drops any partial byte.
        if (cs_rise) begin
            state_d   = ST_IDLE;
            sel_d     = '0;
            strobe_d  = 1'b0;
            start_d   = 1'b0;
            tx_d      = '0;
            bit_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= ST_WAIT_HIGH;
            bit_cnt_q <= '0;
            rx_q      <= '0;
            tx_q      <= '0;
            sel_q     <= '0;
            strobe_q  <= 1'b0;
            start_q   <= 1'b0;
            dout_q    <= '0;
            load_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            rx_q      <= rx_d;
            tx_q      <= tx_d;
            sel_q     <= sel_d;
            strobe_q  <= strobe_d;
            start_q   <= start_d;
            dout_q    <= dout_d;
            load_q    <= load_d;
        end
    end

`ifdef MCU_SPI_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            timeout_q <= '0;
            ferr_q    <= 1'b0;
        end else begin
            timeout_q <= timeout_d;
            ferr_q    <= ferr_d;
        end
    end
    assign frame_error = ferr_q;
`else
    assign frame_error = 1'b0;
`endif

    assign spi_miso        = tx_q[7];
    assign target_sel      = sel_q;
    assign data_out_strobe = strobe_q;
    assign data_out_start  = start_q;
    assign data_out        = dout_q;

endmodule

// File: tb/tb_mcu_spi_target.sv
// Directed bench for mcu_spi_target: SPI mode 0 master model, strobe/reply monitor, assertion checks.
module tb_mcu_spi_target;

    logic       clk      = 1'b0;
    logic       reset_n  = 1'b0;
    logic       spi_cs_n = 1'b1;
    logic       spi_sck  = 1'b0;
    logic       spi_mosi = 1'b0;
    logic       spi_miso;
    logic [3:0] target_sel;
    logic       data_out_strobe;
    logic       data_out_start;
    logic [7:0] data_out;
    logic [7:0] data_in  = 8'hFF;
    logic       frame_error;

    int checks        = 0;
    int failures      = 0;
    int strobe_cnt    = 0;
    int frame_base    = 0;
    int miso_high_cnt = 0;
    int ferr_cnt      = 0;

    logic [7:0] cap_data  [0:31];
    logic       cap_start [0:31];
    logic [3:0] cap_sel   [0:31];

    mcu_spi_target #(
        .SYNC_STAGES(2),
        .NUM_TARGETS(4),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .spi_cs_n(spi_cs_n),
        .spi_sck(spi_sck),
        .spi_mosi(spi_mosi),
        .spi_miso(spi_miso),
        .target_sel(target_sel),
        .data_out_strobe(data_out_strobe),
        .data_out_start(data_out_start),
        .data_out(data_out),
        .data_in(data_in),
        .frame_error(frame_error)
    );

    always #5 clk = ~clk;

    // Records strobes and plays the target: reply 5C to the first strobe of a frame, 42 to the second.
    always @(negedge clk) begin
        if (spi_miso === 1'b1) miso_high_cnt <= miso_high_cnt + 1;
        if (frame_error === 1'b1) ferr_cnt <= ferr_cnt + 1;
        if (data_out_strobe === 1'b1) begin
            cap_data[strobe_cnt % 32]  <= data_out;
            cap_start[strobe_cnt % 32] <= data_out_start;
            cap_sel[strobe_cnt % 32]   <= target_sel;
            case (strobe_cnt - frame_base)
                0:       data_in <= 8'h5C;
                1:       data_in <= 8'h42;
                default: data_in <= 8'hFF;
            endcase
            strobe_cnt <= strobe_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-16s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One byte (or the first nbits of it), MSB first; MISO captured at each SCK rise.
    task automatic spi_byte(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            spi_mosi = tx[i];
            #80;
            spi_sck = 1'b1;
            rx[i]   = spi_miso;
            #80;
            spi_sck = 1'b0;
        end
    endtask

    task automatic cs_low();
        spi_cs_n = 1'b0;
        #80;
    endtask

    task automatic cs_high();
        #80;
        spi_cs_n = 1'b1;
        repeat (10) @(negedge clk);
        #2;
    endtask

    initial begin
        logic [7:0] mrx [0:3];
        logic [7:0] rx_unused;
        int         s0;
        int         m0;
`ifdef MCU_SPI_TIMEOUT_EN
        int         hit;
`endif

        repeat (4) @(negedge clk);
        #2;
        chk("rst_sel", 32'(target_sel), 32'h0);
        chk("rst_strobe", 32'(data_out_strobe), 32'h0);
        chk("rst_start", 32'(data_out_start), 32'h0);
        chk("rst_dout", 32'(data_out), 32'h0);
        chk("rst_miso", 32'(spi_miso), 32'h0);
        chk("rst_ferr", 32'(frame_error), 32'h0);
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        #2;

        // Frame 00,00,AA,BB: target SYS, replies 5C then 42
        frame_base = strobe_cnt;
        s0 = strobe_cnt;
        cs_low();
        spi_byte(8'h00, 8, mrx[0]);
        spi_byte(8'h00, 8, mrx[1]);
        chk("t1_sel_mid", 32'(target_sel), 32'h1);
        spi_byte(8'hAA, 8, mrx[2]);
        spi_byte(8'hBB, 8, mrx[3]);
        cs_high();
        chk("t1_nstrobe", 32'(strobe_cnt - s0), 32'd3);
        chk("t1_d0", 32'(cap_data[s0]), 32'h00);
        chk("t1_st0", 32'(cap_start[s0]), 32'h1);
        chk("t1_sel0", 32'(cap_sel[s0]), 32'h1);
        chk("t1_d1", 32'(cap_data[s0+1]), 32'hAA);
        chk("t1_st1", 32'(cap_start[s0+1]), 32'h0);
        chk("t1_d2", 32'(cap_data[s0+2]), 32'hBB);
        chk("t1_st2", 32'(cap_start[s0+2]), 32'h0);
        chk("t1_miso0", 32'(mrx[0]), 32'h00);
        chk("t1_miso1", 32'(mrx[1]), 32'h00);
        chk("t1_miso2", 32'(mrx[2]), 32'h5C);
        chk("t1_miso3", 32'(mrx[3]), 32'h42);
        chk("t1_sel_end", 32'(target_sel), 32'h0);

        // Frame 02,05,01: target SDC; target_sel clears one cycle after synchronised CS rise
        frame_base = strobe_cnt;
        s0 = strobe_cnt;
        cs_low();
        spi_byte(8'h02, 8, mrx[0]);
        spi_byte(8'h05, 8, mrx[1]);
        chk("t2_sel_mid", 32'(target_sel), 32'h4);
        spi_byte(8'h01, 8, mrx[2]);
        #80;
        spi_cs_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("t2_sel_hold", 32'(target_sel), 32'h4);
        @(negedge clk);
        chk("t2_sel_clr", 32'(target_sel), 32'h0);
        repeat (8) @(negedge clk);
        #2;
        chk("t2_nstrobe", 32'(strobe_cnt - s0), 32'd2);
        chk("t2_d0", 32'(cap_data[s0]), 32'h05);
        chk("t2_st0", 32'(cap_start[s0]), 32'h1);
        chk("t2_d1", 32'(cap_data[s0+1]), 32'h01);
        chk("t2_st1", 32'(cap_start[s0+1]), 32'h0);
        chk("t2_miso2", 32'(mrx[2]), 32'h5C);

        // Target id 07 is out of range: silent frame
        s0 = strobe_cnt;
        m0 = miso_high_cnt;
        cs_low();
        spi_byte(8'h07, 8, rx_unused);
        spi_byte(8'h11, 8, rx_unused);
        chk("t3_sel_mid", 32'(target_sel), 32'h0);
        spi_byte(8'h22, 8, rx_unused);
        spi_byte(8'h33, 8, rx_unused);
        cs_high();
        chk("t3_nstrobe", 32'(strobe_cnt - s0), 32'd0);
        chk("t3_miso_high", 32'(miso_high_cnt - m0), 32'd0);

        // Abort after 5 command bits, then a clean frame 01,03
        s0 = strobe_cnt;
        cs_low();
        spi_byte(8'h01, 8, rx_unused);
        spi_byte(8'h55, 5, rx_unused);
        cs_high();
        chk("t4_abort_nstb", 32'(strobe_cnt - s0), 32'd0);
        chk("t4_abort_sel", 32'(target_sel), 32'h0);
        frame_base = strobe_cnt;
        s0 = strobe_cnt;
        cs_low();
        spi_byte(8'h01, 8, rx_unused);
        spi_byte(8'h03, 8, rx_unused);
        cs_high();
        chk("t4_nstrobe", 32'(strobe_cnt - s0), 32'd1);
        chk("t4_d0", 32'(cap_data[s0]), 32'h03);
        chk("t4_st0", 32'(cap_start[s0]), 32'h1);
        chk("t4_sel0", 32'(cap_sel[s0]), 32'h2);

        // Reset mid-frame with CS held low
        s0 = strobe_cnt;
        cs_low();
        spi_byte(8'h00, 8, rx_unused);
        spi_byte(8'h55, 4, rx_unused);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("t5_rst_sel", 32'(target_sel), 32'h0);
        chk("t5_rst_strobe", 32'(data_out_strobe), 32'h0);
        chk("t5_rst_dout", 32'(data_out), 32'h0);
        chk("t5_rst_miso", 32'(spi_miso), 32'h0);
        #2;
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        #2;
        spi_byte(8'h00, 8, rx_unused);
        spi_byte(8'h77, 8, rx_unused);
        #80;
        chk("t5_held_nstb", 32'(strobe_cnt - s0), 32'd0);
        chk("t5_held_sel", 32'(target_sel), 32'h0);
        cs_high();
        frame_base = strobe_cnt;
        s0 = strobe_cnt;
        cs_low();
        spi_byte(8'h00, 8, rx_unused);
        spi_byte(8'h66, 8, rx_unused);
        cs_high();
        chk("t5_nstrobe", 32'(strobe_cnt - s0), 32'd1);
        chk("t5_d0", 32'(cap_data[s0]), 32'h66);
        chk("t5_st0", 32'(cap_start[s0]), 32'h1);
        chk("ferr_none", 32'(ferr_cnt), 32'd0);

`ifdef MCU_SPI_TIMEOUT_EN
        // Stall after the target byte and 3 command bits
        s0  = strobe_cnt;
        m0  = ferr_cnt;
        hit = -1;
        cs_low();
        spi_byte(8'h00, 8, rx_unused);
        spi_byte(8'hA0, 3, rx_unused);
        chk("t6_sel_pre", 32'(target_sel), 32'h1);
        for (int c = 1; c <= 150; c++) begin
            @(negedge clk);
            if (hit < 0 && ferr_cnt != m0) hit = c;
        end
        #2;
        chk("t6_ferr_once", 32'(ferr_cnt - m0), 32'd1);
        chk("t6_ferr_window", 32'(hit >= 98 && hit <= 108), 32'd1);
        chk("t6_sel_clr", 32'(target_sel), 32'h0);
        spi_byte(8'hFF, 5, rx_unused);
        spi_byte(8'h12, 8, rx_unused);
        #80;
        chk("t6_ignored_nstb", 32'(strobe_cnt - s0), 32'd0);
        cs_high();
        frame_base = strobe_cnt;
        s0 = strobe_cnt;
        cs_low();
        spi_byte(8'h00, 8, rx_unused);
        spi_byte(8'h9A, 8, rx_unused);
        cs_high();
        chk("t6_nstrobe", 32'(strobe_cnt - s0), 32'd1);
        chk("t6_d0", 32'(cap_data[s0]), 32'h9A);
        chk("t6_ferr_total", 32'(ferr_cnt - m0), 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
